// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control FSM for the CompactRISC16 datapath.
// Sequences each instruction through FETCH, DECODE, EXECUTE and, for memory
// instructions, MEM and WRITEBACK. The state is registered; every output is
// decoded combinationally from the state, the instruction register and the
// memory/condition inputs, and is forced low while reset is held.
module cpu_controller #(
   parameter int P_WIDTH = 16
) (
   input  logic               I_CLK,
   input  logic               I_RESET,
   input  logic [P_WIDTH-1:0] I_IR,
   input  logic               I_MEM_READY,
   input  logic               I_COND_TRUE,
   output logic               O_IR_EN,
   output logic               O_PC_EN,
   output logic [1:0]         O_PC_SEL,
   output logic               O_RF_WE,
   output logic [1:0]         O_WB_SEL,
   output logic               O_FLAGS_EN,
   output logic               O_MEM_ADDR_SEL,
   output logic               O_MEM_WE,
   output logic [2:0]         O_STATE
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_CMP,
      CLS_NOP,
      CLS_LOAD,
      CLS_STOR,
      CLS_JAL,
      CLS_JCOND,
      CLS_BCOND
   } cls_t;

   // Mux-select encodings shared with the datapath.
   localparam logic [1:0] PC_INC  = 2'b00;
   localparam logic [1:0] PC_DISP = 2'b01;
   localparam logic [1:0] PC_REG  = 2'b10;
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   state_t     state_reg;
   state_t     state_next;
   cls_t       ir_cls;
   logic [3:0] opcode;
   logic [3:0] opext;

   // Register/immediate fields are consumed by the datapath, not by control.
   logic       unused_ir_bits;

   assign opcode         = I_IR[15:12];
   assign opext          = I_IR[7:4];
   assign unused_ir_bits = ^{I_IR[11:8], I_IR[3:0]};

   // Classify the instruction held in the IR; only meaningful from DECODE on.
   always_comb begin
      ir_cls = CLS_ALU;
      if (opcode == 4'b0100) begin
         case (opext)
            4'b0000: ir_cls = CLS_LOAD;
            4'b0100: ir_cls = CLS_STOR;
            4'b1000: ir_cls = CLS_JAL;
            4'b1100: ir_cls = CLS_JCOND;
            default: ir_cls = CLS_NOP;
         endcase
      end else if (opcode == 4'b1100) begin
         ir_cls = CLS_BCOND;
      end else if (opcode == 4'b1011 || (opcode == 4'b0000 && opext == 4'b1011)) begin
         ir_cls = CLS_CMP;
      end
   end

   // Next-state and output decode; reset masks every output in the same cycle.
   always_comb begin
      state_next     = state_reg;
      O_IR_EN        = 1'b0;
      O_PC_EN        = 1'b0;
      O_PC_SEL       = PC_INC;
      O_RF_WE        = 1'b0;
      O_WB_SEL       = WB_ALU;
      O_FLAGS_EN     = 1'b0;
      O_MEM_ADDR_SEL = 1'b0;
      O_MEM_WE       = 1'b0;
      O_STATE        = state_reg;

      case (state_reg)
         ST_FETCH: begin
            if (I_MEM_READY) begin
               O_IR_EN    = 1'b1;
               state_next = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (ir_cls == CLS_LOAD || ir_cls == CLS_STOR) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_EXECUTE;
            end
         end

         ST_EXECUTE: begin
            O_PC_EN    = 1'b1;
            state_next = ST_FETCH;
            case (ir_cls)
               CLS_ALU: begin
                  O_RF_WE    = 1'b1;
                  O_WB_SEL   = WB_ALU;
                  O_FLAGS_EN = 1'b1;
               end
               CLS_CMP:   O_FLAGS_EN = 1'b1;
               CLS_BCOND: O_PC_SEL   = I_COND_TRUE ? PC_DISP : PC_INC;
               CLS_JCOND: O_PC_SEL   = I_COND_TRUE ? PC_REG : PC_INC;
               CLS_JAL: begin
                  O_RF_WE  = 1'b1;
                  O_WB_SEL = WB_LINK;
                  O_PC_SEL = PC_REG;
               end
               default: O_PC_SEL = PC_INC;
            endcase
         end

         ST_MEM: begin
            O_MEM_ADDR_SEL = 1'b1;
            if (ir_cls == CLS_STOR) begin
               // The write strobe is held for the whole wait, not just the final cycle.
               O_MEM_WE = 1'b1;
               if (I_MEM_READY) begin
                  O_PC_EN    = 1'b1;
                  state_next = ST_FETCH;
               end
            end else if (I_MEM_READY) begin
               state_next = ST_WRITEBACK;
            end
         end

         ST_WRITEBACK: begin
            O_RF_WE    = 1'b1;
            O_WB_SEL   = WB_MEM;
            O_PC_EN    = 1'b1;
            state_next = ST_FETCH;
         end

         default: state_next = ST_FETCH;
      endcase

      if (I_RESET) begin
         O_IR_EN        = 1'b0;
         O_PC_EN        = 1'b0;
         O_PC_SEL       = PC_INC;
         O_RF_WE        = 1'b0;
         O_WB_SEL       = WB_ALU;
         O_FLAGS_EN     = 1'b0;
         O_MEM_ADDR_SEL = 1'b0;
         O_MEM_WE       = 1'b0;
         O_STATE        = 3'd0;
      end
   end

   // State register; reset aborts any instruction in flight and restarts fetch.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle expected output vectors,
// checked 2 time units after each rising edge.
module tb_cpu_controller;

   logic        I_CLK = 1'b0;
   logic        I_RESET;
   logic [15:0] I_IR;
   logic        I_MEM_READY;
   logic        I_COND_TRUE;
   logic        O_IR_EN;
   logic        O_PC_EN;
   logic [1:0]  O_PC_SEL;
   logic        O_RF_WE;
   logic [1:0]  O_WB_SEL;
   logic        O_FLAGS_EN;
   logic        O_MEM_ADDR_SEL;
   logic        O_MEM_WE;
   logic [2:0]  O_STATE;

   int n_total = 0;
   int n_bad   = 0;

   cpu_controller #(.P_WIDTH(16)) dut (
      .I_CLK          (I_CLK),
      .I_RESET        (I_RESET),
      .I_IR           (I_IR),
      .I_MEM_READY    (I_MEM_READY),
      .I_COND_TRUE    (I_COND_TRUE),
      .O_IR_EN        (O_IR_EN),
      .O_PC_EN        (O_PC_EN),
      .O_PC_SEL       (O_PC_SEL),
      .O_RF_WE        (O_RF_WE),
      .O_WB_SEL       (O_WB_SEL),
      .O_FLAGS_EN     (O_FLAGS_EN),
      .O_MEM_ADDR_SEL (O_MEM_ADDR_SEL),
      .O_MEM_WE       (O_MEM_WE),
      .O_STATE        (O_STATE)
   );

   always #5 I_CLK = ~I_CLK;

   // Packed view: {ir_en, pc_en, pc_sel, rf_we, wb_sel, flags_en, mem_addr_sel, mem_we, state}
   function automatic logic [13:0] ev(input logic ir, input logic pc, input logic [1:0] psel,
                                      input logic rf, input logic [1:0] wb, input logic fl,
                                      input logic mas, input logic mwe, input logic [2:0] st);
      return {ir, pc, psel, rf, wb, fl, mas, mwe, st};
   endfunction

   task automatic chk_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end else begin
         $display("ok   %s %b", tag, obs);
      end
   endtask

   // Check the current cycle's outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [13:0] exp);
      #1;
      chk_eq(tag, {O_IR_EN, O_PC_EN, O_PC_SEL, O_RF_WE, O_WB_SEL, O_FLAGS_EN,
                   O_MEM_ADDR_SEL, O_MEM_WE, O_STATE}, exp);
      @(posedge I_CLK);
      #1;
   endtask

   // Fetch + decode for a non-memory instruction, then check EXECUTE.
   task automatic run_exec(input string tag, input logic [15:0] ir, input logic cond,
                           input logic [13:0] exp_ex);
      I_IR        = ir;
      I_COND_TRUE = cond;
      I_MEM_READY = 1'b1;
      cyc({tag, "_f"}, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc({tag, "_d"}, ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc({tag, "_e"}, exp_ex);
   endtask

   localparam logic [13:0] ZERO = 14'd0;

   initial begin
      I_RESET     = 1'b1;
      I_IR        = 16'h0000;
      I_MEM_READY = 1'b1;
      I_COND_TRUE = 1'b0;
      @(posedge I_CLK);
      #1;
      cyc("reset_hold", ZERO);
      I_RESET = 1'b0;

      // ADD: 0,1,2 then back to 0
      run_exec("add", 16'h0152, 1'b0, ev(0, 1, 0, 1, 0, 1, 0, 0, 2));

      // FETCH wait adds a cycle with no enables
      I_MEM_READY = 1'b0;
      cyc("fetch_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // LOAD with two wait cycles in MEM: 0,1,3,3,3,4
      I_IR        = 16'h4203;
      I_MEM_READY = 1'b1;
      cyc("ld_f", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("ld_d", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
      I_MEM_READY = 1'b0;
      cyc("ld_m_w1", ev(0, 0, 0, 0, 0, 0, 1, 0, 3));
      cyc("ld_m_w2", ev(0, 0, 0, 0, 0, 0, 1, 0, 3));
      I_MEM_READY = 1'b1;
      cyc("ld_m_rdy", ev(0, 0, 0, 0, 0, 0, 1, 0, 3));
      cyc("ld_wb", ev(0, 1, 0, 1, 1, 0, 0, 0, 4));

      // STOR with one wait cycle: MEM_WE held two cycles, PC_EN in the second
      I_IR = 16'h4346;
      cyc("st_f", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("st_d", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
      I_MEM_READY = 1'b0;
      cyc("st_m_w", ev(0, 0, 0, 0, 0, 0, 1, 1, 3));
      I_MEM_READY = 1'b1;
      cyc("st_m_rdy", ev(0, 1, 0, 0, 0, 0, 1, 1, 3));

      // Branches and jumps
      run_exec("bc_t", 16'hC105, 1'b1, ev(0, 1, 1, 0, 0, 0, 0, 0, 2));
      run_exec("bc_f", 16'hC105, 1'b0, ev(0, 1, 0, 0, 0, 0, 0, 0, 2));
      run_exec("jc_t", 16'h41C2, 1'b1, ev(0, 1, 2, 0, 0, 0, 0, 0, 2));
      run_exec("jc_f", 16'h41C2, 1'b0, ev(0, 1, 0, 0, 0, 0, 0, 0, 2));
      run_exec("jal",  16'h4A8B, 1'b0, ev(0, 1, 2, 1, 2, 0, 0, 0, 2));
      run_exec("cmp0", 16'h0BB1, 1'b1, ev(0, 1, 0, 0, 0, 1, 0, 0, 2));
      run_exec("cmpb", 16'hB123, 1'b0, ev(0, 1, 0, 0, 0, 1, 0, 0, 2));
      run_exec("nop",  16'h4010, 1'b1, ev(0, 1, 0, 0, 0, 0, 0, 0, 2));

      // Reset in MEM of a STOR: outputs drop immediately, no PC_EN afterwards
      I_IR        = 16'h4346;
      I_COND_TRUE = 1'b0;
      cyc("rst_st_f", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("rst_st_d", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
      I_MEM_READY = 1'b0;
      cyc("rst_st_m", ev(0, 0, 0, 0, 0, 0, 1, 1, 3));
      I_RESET     = 1'b1;
      I_MEM_READY = 1'b1;
      cyc("rst_st_abort", ZERO);
      I_RESET = 1'b0;
      I_IR    = 16'h0152;
      cyc("rst_refetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("rst_dec", ev(0, 0, 0, 0, 0, 0, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
